short_hash_pipe: RTL

SHORT_HASH_PIPE -- requirements
Module: short_hash_pipe

---
 rtl/short_hash_pipe.sv | 132 +++++++++++++
 1 files changed

// File: rtl/short_hash_pipe.sv
// Purpose: NROUNDS-stage add/rotate/xor mixing pipeline that joins a data beat with a tap beat.
// Latency: NROUNDS+1 cycles from the accepting cycle to m_tap_valid; one item per cycle.
// Backpressure: bubbles collapse; a full pipeline stalls every stage and drops both input readies.
module short_hash_pipe #(
    parameter int W       = 64,
    parameter int NROUNDS = 11,
    parameter int LENW    = 8,
    parameter int OCCW    = $clog2(NROUNDS + 2)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [2*W+LENW-1:0]   s_dat_data,
    input  logic                  s_dat_valid,
    output logic                  s_dat_ready,
    input  logic [4*W-1:0]        s_tap_data,
    input  logic                  s_tap_valid,
    output logic                  s_tap_ready,
    output logic [4*W-1:0]        m_tap_data,
    output logic                  m_tap_valid,
    input  logic                  m_tap_ready,
    output logic [OCCW-1:0]       occ
);

    // Lane index 0 = a (LSBs) ... 3 = d, so a stage packs directly as {d,c,b,a}.
    typedef logic [3:0][W-1:0] lanes_t;

    lanes_t             st [0:NROUNDS];
    lanes_t             ld;
    logic [NROUNDS:0]   vld;
    logic [NROUNDS:0]   adv;
    logic [W-1:0]       lenx;
    logic               run;
    logic               fire;
    logic               deliver;

    function automatic int rot_amt(input int k);
        int r;
        case ((k - 1) % 11)
            0:       r = 15;
            1:       r = 52;
            2:       r = 26;
            3:       r = 51;
            4:       r = 28;
            5:       r = 9;
            6:       r = 47;
            7:       r = 54;
            8:       r = 32;
            9:       r = 25;
            default: r = 63;
        endcase
        return r % W;
    endfunction

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int r);
        if (r == 0) return x;
        return (x << r) | (x >> (W - r));
    endfunction

    // Round k rotates the (y,x) role pair one lane per round: y = lane (k+2)%4, x = lane (k+1)%4.
    function automatic lanes_t mix(input lanes_t s, input int k);
        logic [1:0]   yi;
        logic [1:0]   xi;
        logic [W-1:0] xt;
        logic [W-1:0] xr;
        yi    = 2'(k + 2);
        xi    = 2'(k + 1);
        xt    = s[xi];
        xr    = rotl(xt, rot_amt(k));
        s[yi] = (s[yi] ^ xt) + xr;
        s[xi] = xr;
        return s;
    endfunction

    always_comb begin
        lenx  = W'(s_dat_data[2*W +: LENW]);
        ld    = '0;
        ld[0] = s_tap_data[0*W +: W] ^ lenx;
        ld[1] = s_tap_data[1*W +: W] ^ ~lenx;
        ld[2] = s_tap_data[2*W +: W] + s_dat_data[0 +: W];
        ld[3] = s_tap_data[3*W +: W] + s_dat_data[W +: W];
    end

    always_comb begin : adv_chain
        logic acc;
        adv          = '0;
        acc          = !vld[NROUNDS] || m_tap_ready;
        adv[NROUNDS] = acc;
        for (int k = NROUNDS - 1; k >= 0; k--) begin
            acc    = acc || !vld[k];
            adv[k] = acc;
        end
    end

    // run holds the input side closed until the first edge after reset release.
    assign s_dat_ready = run && s_tap_valid && adv[0] && !flush;
    assign s_tap_ready = run && s_dat_valid && adv[0] && !flush;
    assign fire        = run && s_dat_valid && s_tap_valid && adv[0] && !flush;
    assign deliver     = vld[NROUNDS] && m_tap_ready;
    assign m_tap_valid = vld[NROUNDS];
    assign m_tap_data  = st[NROUNDS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run <= 1'b0;
            vld <= '0;
            occ <= '0;
            for (int i = 0; i <= NROUNDS; i++) st[i] <= '0;
        end else begin
            run <= 1'b1;
            if (flush) begin
                vld <= '0;
                occ <= '0;
            end else begin
                if (adv[0]) vld[0] <= fire;
                if (fire)   st[0]  <= ld;
                for (int k = 1; k <= NROUNDS; k++) begin
                    if (adv[k]) begin
                        vld[k] <= vld[k-1];
                        if (vld[k-1]) st[k] <= mix(st[k-1], k);
                    end
                end
                case ({fire, deliver})
                    2'b10:   occ <= occ + OCCW'(1);
                    2'b01:   occ <= occ - OCCW'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule
